io_write_arbiter: RTL and testbench
===================================

IO_WRITE_ARBITER -- requirements
Module: io_write_arbiter

Interface
REQ-001 SHALL have parameter AW, default 15, meaning address width.
REQ-002 SHALL have parameter DW, default 16, meaning data width.
REQ-003 SHALL have parameter MAP_BASE, default 15'h7000, meaning first valid memory-mapped IO address.
REQ-004 SHALL have parameter MAP_SIZE, default 16, meaning number of valid IO words starting at MAP_BASE.
REQ-005 SHALL have parameter MAX_BURST, default 4, meaning maximum consecutive locked writes per grant (range 1..15).
REQ-006 SHALL use one clock; reset is synchronous and active-high. Ports: clk50m  in  1  clock, rising edge; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: req  in  2  per-requester write request, held until its gnt bit is seen.
REQ-008 SHALL have ports: lock  in  2  per-requester burst hold request, valid while req is high.
REQ-009 SHALL have ports: addr0/addr1  in  AW  requester addresses; data0/data1  in  DW  requester write data, stable while req is high.
REQ-010 SHALL have ports: err_clr  in  1  clears err.
REQ-011 SHALL have ports: gnt  out  2  one-cycle write-accepted pulse per requester.
REQ-012 SHALL have ports: bus_addr  out  AW, bus_data  out  DW, bus_we  out  1  shared write bus to IO register slices.
REQ-013 SHALL have ports: busy  out  1  high when state is not IDLE; err  out  1  sticky out-of-range flag.

Function
REQ-014 SHALL register all outputs; no combinational path from any input to any output.
REQ-015 SHALL implement states IDLE, WRITE and HOLD.
REQ-016 In IDLE with any req high, SHALL pick a winner by round-robin, capture its addr/data into bus_addr/bus_data, and enter WRITE; with no req, SHALL stay in IDLE.
REQ-017 In WRITE (exactly one cycle), SHALL drive gnt[winner]=1 and bus_we=1, or bus_we=0 if the captured address is out of range.
REQ-018 Latency SHALL be one cycle: a req sampled in IDLE at edge N yields bus_we/gnt during cycle N+1.
REQ-019 Requesters SHALL update or drop req/addr/data on the edge ending their gnt cycle; the arbiter SHALL NOT sample requester inputs on that edge, so sustained throughput is at most one write per two cycles.
REQ-020 From WRITE, SHALL enter HOLD if lock[winner]=1 and the burst count is below MAX_BURST; otherwise SHALL enter IDLE.
REQ-021 In HOLD, SHALL serve only the owner: if req[owner]=1, capture and enter WRITE; if req[owner]=0 or lock[owner]=0, enter IDLE; other requesters wait.
REQ-022 Round-robin pointer SHALL point to the non-winner after every IDLE-to-WRITE grant; when both req are high in IDLE, the pointed requester SHALL win.
REQ-023 A burst counter (4 bits) SHALL load 1 on the IDLE-to-WRITE transition and increment on each HOLD-to-WRITE transition; reaching MAX_BURST SHALL force IDLE after that WRITE.
REQ-024 Out of range SHALL mean addr < MAP_BASE or addr >= MAP_BASE+MAP_SIZE, compared at AW+1 bits to avoid wrap.
REQ-025 An out-of-range write SHALL still pulse gnt and set err; err SHALL stay set until err_clr.
REQ-026 If err_clr and a new out-of-range WRITE occur in the same cycle, err SHALL remain 1 (set wins).
REQ-027 bus_addr/bus_data SHALL hold their last captured values when bus_we=0.

Reset
REQ-028 On rst at a rising edge: state=IDLE, gnt=0, bus_we=0, bus_addr=0, bus_data=0, busy=0, err=0, pointer=requester 0, burst counter=0.
REQ-029 rst SHALL take priority over all other inputs; a write in progress SHALL be aborted with no gnt and no bus_we after the reset edge.

Structure
REQ-030 Package io_arb_pkg SHALL hold the state enum (IDLE, WRITE, HOLD) and the requester index type.
REQ-031 A sub-module rr_arbiter2 (2-way round-robin picker: req, pointer -> one-hot winner) SHALL be instantiated once.

Verification
REQ-032 req=01, addr0=7003, data0=ABCD -> cycle+1: bus_we=1, bus_addr=7003, bus_data=ABCD, gnt=01; next cycle state IDLE.
REQ-033 req=11 held from reset -> grants alternate 01,10,01,10 with one idle cycle between writes.
REQ-034 req0+lock0 with 6 queued writes, req1 also high -> 4 consecutive gnt0 (HOLD between), then gnt1 before gnt0 resumes.
REQ-035 addr1=6FFF, then addr1=7010 -> gnt=10 both times, bus_we=0, err=1; err_clr pulse -> err=0.
REQ-036 rst asserted in the WRITE cycle -> next cycle gnt=00, bus_we=0, busy=0, pointer back to requester 0.

Source files
------------

// File: rtl/io_write_arbiter_pkg.sv
// Shared types for the IO write arbiter: FSM states, requester index and a
// small helper that turns a requester index into its one-hot grant vector.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

    typedef logic req_idx_t;

    function automatic logic [1:0] idx_to_onehot(input req_idx_t idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/io_write_arbiter_if.sv
// Request/write-bus bundle between the two IO requesters (master) and the
// write arbiter (slave).
interface io_write_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 16
);
    logic [1:0]    req;
    logic [1:0]    lock;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          err_clr;
    logic [1:0]    gnt;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data;
    logic          bus_we;
    logic          busy;
    logic          err;

    modport master (
        output req, lock, addr0, addr1, data0, data1, err_clr,
        input  gnt, bus_addr, bus_data, bus_we, busy, err
    );

    modport slave (
        input  req, lock, addr0, addr1, data0, data1, err_clr,
        output gnt, bus_addr, bus_data, bus_we, busy, err
    );
endinterface

// File: rtl/io_write_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: a lone request always wins, and on a tie the
// requester named by the pointer wins.
module rr_arbiter2
    import io_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   pointer,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = idx_to_onehot(pointer);
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/io_write_arbiter.sv
// IO write arbiter: two requesters share one registered write bus into the IO
// map, with round-robin fairness, locked bursts and a sticky out-of-range flag.
module io_write_arbiter
    import io_arb_pkg::*;
#(
    parameter int          AW        = 15,
    parameter int          DW        = 16,
    parameter int unsigned MAP_BASE  = 32'h7000,
    parameter int unsigned MAP_SIZE  = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input logic               clk50m,
    input logic               rst,
    io_write_arbiter_if.slave arb
);

    // One extra bit keeps MAP_BASE+MAP_SIZE from wrapping at the top of the space.
    localparam logic [AW:0] MAP_LO      = (AW+1)'(MAP_BASE);
    localparam logic [AW:0] MAP_HI      = (AW+1)'(MAP_BASE + MAP_SIZE);
    localparam logic [3:0]  BURST_LIMIT = 4'(MAX_BURST);

    arb_state_t    state_q, state_d;
    req_idx_t      ptr_q, ptr_d;
    req_idx_t      owner_q, owner_d;
    req_idx_t      cap_idx;
    logic [3:0]    burst_q, burst_d;
    logic [1:0]    win_oh;
    logic [1:0]    gnt_q;
    logic          capture;
    logic          cap_in_map;
    logic          bus_we_q;
    logic          busy_q;
    logic          err_q;
    logic [AW-1:0] cap_addr, bus_addr_q;
    logic [DW-1:0] cap_data, bus_data_q;
    logic [AW:0]   cap_addr_ext;

    rr_arbiter2 u_rr (
        .req     (arb.req),
        .pointer (ptr_q),
        .grant   (win_oh)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        capture = 1'b0;
        cap_idx = owner_q;
        case (state_q)
            IDLE: begin
                if (win_oh != 2'b00) begin
                    capture = 1'b1;
                    cap_idx = win_oh[1];
                    owner_d = win_oh[1];
                    ptr_d   = ~win_oh[1];
                    burst_d = 4'd1;
                    state_d = WRITE;
                end
            end
            // The requester swaps its inputs on the edge leaving WRITE, so nothing is captured here.
            WRITE: begin
                if (arb.lock[owner_q] && (burst_q < BURST_LIMIT)) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (arb.req[owner_q] && arb.lock[owner_q]) begin
                    capture = 1'b1;
                    burst_d = burst_q + 4'd1;
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap_addr     = cap_idx ? arb.addr1 : arb.addr0;
        cap_data     = cap_idx ? arb.data1 : arb.data0;
        cap_addr_ext = {1'b0, cap_addr};
        cap_in_map   = (cap_addr_ext >= MAP_LO) && (cap_addr_ext < MAP_HI);
    end

    always_ff @(posedge clk50m) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            burst_q    <= 4'd0;
            gnt_q      <= 2'b00;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            gnt_q    <= capture ? idx_to_onehot(cap_idx) : 2'b00;
            bus_we_q <= capture && cap_in_map;
            busy_q   <= (state_d != IDLE);
            if (capture) begin
                bus_addr_q <= cap_addr;
                bus_data_q <= cap_data;
            end
            // A suppressed write in WRITE means out of range; setting beats clearing.
            if ((state_q == WRITE) && !bus_we_q) begin
                err_q <= 1'b1;
            end else if (arb.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign arb.gnt      = gnt_q;
    assign arb.bus_we   = bus_we_q;
    assign arb.bus_addr = bus_addr_q;
    assign arb.bus_data = bus_data_q;
    assign arb.busy     = busy_q;
    assign arb.err      = err_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Scoreboard bench for io_write_arbiter: requesters push expected writes when
// they present them, and each granted bus write pops and compares one entry.
module tb_io_write_arbiter;

    logic clk50m;
    logic rst;

    io_write_arbiter_if #(.AW(15), .DW(16)) arb ();

    io_write_arbiter #(
        .AW        (15),
        .DW        (16),
        .MAP_BASE  (32'h7000),
        .MAP_SIZE  (16),
        .MAX_BURST (4)
    ) dut (
        .clk50m (clk50m),
        .rst    (rst),
        .arb    (arb)
    );

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
        logic        we;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rem[2];
    logic [14:0] nxt_addr[2];
    logic        lk_cfg[2];

    initial clk50m = 1'b0;
    always #10 clk50m = ~clk50m;

    // A requester puts a write on its port and records what the bus must show for it.
    task automatic present(input int i, input logic [14:0] a, input logic [15:0] d, input logic lk);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.we   = (a >= 15'h7000) && ({1'b0, a} < 16'h7010);
        if (i == 0) begin
            arb.addr0 = a; arb.data0 = d; arb.lock[0] = lk; arb.req[0] = 1'b1;
            sb0.push_back(e);
        end else begin
            arb.addr1 = a; arb.data1 = d; arb.lock[1] = lk; arb.req[1] = 1'b1;
            sb1.push_back(e);
        end
    endtask

    task automatic drop(input int i);
        arb.req[i]  = 1'b0;
        arb.lock[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arb.req = 2'b00; arb.lock = 2'b00; arb.err_clr = 1'b0;
        sb0.delete(); sb1.delete();
        repeat (2) @(posedge clk50m);
        #1 rst = 1'b0;
    endtask

    task automatic start_traffic(input int n0, input int n1, input logic [14:0] a0,
                                 input logic [14:0] a1, input logic l0, input logic l1);
        rem[0] = n0; rem[1] = n1;
        nxt_addr[0] = a0; nxt_addr[1] = a1;
        lk_cfg[0] = l0; lk_cfg[1] = l1;
        if (n0 > 0) present(0, a0, 16'($urandom), l0);
        if (n1 > 0) present(1, a1, 16'($urandom), l1);
    endtask

    // On the edge that ends a gnt cycle, the granted requester moves to its next write or drops.
    task automatic advance(input logic [1:0] g);
        @(posedge clk50m);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                rem[i]--;
                if (rem[i] > 0) begin
                    nxt_addr[i] = nxt_addr[i] + 15'd1;
                    present(i, nxt_addr[i], 16'($urandom), lk_cfg[i]);
                end else begin
                    drop(i);
                end
            end
        end
    endtask

    // Waits (bounded) for a gnt pulse; gap counts the quiet cycles before it.
    task automatic next_grant(output logic [1:0] g, output logic [14:0] a, output logic [15:0] d,
                              output logic we, output int gap, output logic gap_busy);
        g = 2'b00; a = '0; d = '0; we = 1'b0; gap = 0; gap_busy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk50m);
            if (arb.gnt !== 2'b00) begin
                g = arb.gnt; a = arb.bus_addr; d = arb.bus_data; we = arb.bus_we;
                break;
            end
            gap++;
            gap_busy = arb.busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arb.err_clr = 1'b0;
        arb.lock = 2'b11;
        arb.addr0 = 15'h7001; arb.data0 = 16'h1234;
        arb.addr1 = 15'h7002; arb.data1 = 16'h5678;
        arb.req = 2'b11;
        repeat (2) @(posedge clk50m);
        @(negedge clk50m);
        n_cmp++; if (arb.gnt !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_gnt: got %b want 00", arb.gnt); end
        n_cmp++; if (arb.bus_we !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_we: got %b want 0", arb.bus_we); end
        n_cmp++; if (arb.bus_addr !== 15'h0) begin n_bad++; $display("[TB] FAIL reset_addr: got %h want 0000", arb.bus_addr); end
        n_cmp++; if (arb.bus_data !== 16'h0) begin n_bad++; $display("[TB] FAIL reset_data: got %h want 0000", arb.bus_data); end
        n_cmp++; if (arb.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", arb.busy); end
        n_cmp++; if (arb.err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", arb.err); end
        do_reset();
    endtask

    task automatic test_single();
        logic [1:0] g; logic [14:0] a; logic [15:0] d; logic we; int gap; logic gb; exp_t e;
        do_reset();
        present(0, 15'h7003, 16'hABCD, 1'b0);
        next_grant(g, a, d, we, gap, gb);
        n_cmp++; if (g !== 2'b01) begin n_bad++; $display("[TB] FAIL single_gnt: got %b want 01", g); end
        n_cmp++; if (gap !== 1) begin n_bad++; $display("[TB] FAIL single_latency: got %0d want 1", gap); end
        n_cmp++; if (arb.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL single_busy: got %b want 1", arb.busy); end
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            n_cmp++;
            if ({a, d, we} !== {e.addr, e.data, e.we}) begin
                n_bad++;
                $display("[TB] FAIL single_write: got %h/%h/%b want %h/%h/%b", a, d, we, e.addr, e.data, e.we);
            end
        end
        @(posedge clk50m);
        #1 drop(0);
        @(negedge clk50m);
        n_cmp++; if (arb.gnt !== 2'b00) begin n_bad++; $display("[TB] FAIL single_gnt_end: got %b want 00", arb.gnt); end
        n_cmp++; if (arb.bus_we !== 1'b0) begin n_bad++; $display("[TB] FAIL single_we_end: got %b want 0", arb.bus_we); end
        n_cmp++; if (arb.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_idle: got %b want 0", arb.busy); end
        n_cmp++;
        if ({arb.bus_addr, arb.bus_data} !== {15'h7003, 16'hABCD}) begin
            n_bad++;
            $display("[TB] FAIL single_hold: got %h/%h want 7003/abcd", arb.bus_addr, arb.bus_data);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] g; logic [14:0] a; logic [15:0] d; logic we; int gap; logic gb; exp_t e;
        logic [1:0] exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        arb.req = 2'b00; arb.lock = 2'b00; arb.err_clr = 1'b0;
        sb0.delete(); sb1.delete();
        @(posedge clk50m);
        #1 start_traffic(2, 2, 15'h7000, 15'h7008, 1'b0, 1'b0);
        @(posedge clk50m);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_grant(g, a, d, we, gap, gb);
            n_cmp++; if (g !== exp_g[k]) begin n_bad++; $display("[TB] FAIL alt_gnt[%0d]: got %b want %b", k, g, exp_g[k]); end
            if (g == 2'b00) break;
            n_cmp++; if (gap !== 1 || gb !== 1'b0) begin n_bad++; $display("[TB] FAIL alt_gap[%0d]: got %0d/%b want 1/0", k, gap, gb); end
            if ((g[0] && sb0.size() == 0) || (!g[0] && sb1.size() == 0)) begin
                n_cmp++; n_bad++;
                $display("[TB] FAIL alt_extra[%0d]: got gnt %b want no write", k, g);
                break;
            end
            e = g[0] ? sb0.pop_front() : sb1.pop_front();
            n_cmp++;
            if ({a, d, we} !== {e.addr, e.data, e.we}) begin
                n_bad++;
                $display("[TB] FAIL alt_write[%0d]: got %h/%h/%b want %h/%h/%b", k, a, d, we, e.addr, e.data, e.we);
            end
            advance(g);
        end
        n_cmp++; if (sb0.size() + sb1.size() != 0) begin n_bad++; $display("[TB] FAIL alt_left: got %0d want 0", sb0.size() + sb1.size()); end
    endtask

    task automatic test_burst();
        logic [1:0] g; logic [14:0] a; logic [15:0] d; logic we; int gap; logic gb; exp_t e;
        logic [1:0] exp_g[7]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
        logic       exp_gb[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        start_traffic(6, 1, 15'h7000, 15'h700C, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            next_grant(g, a, d, we, gap, gb);
            n_cmp++; if (g !== exp_g[k]) begin n_bad++; $display("[TB] FAIL burst_gnt[%0d]: got %b want %b", k, g, exp_g[k]); end
            if (g == 2'b00) break;
            n_cmp++;
            if (gap !== 1 || gb !== exp_gb[k]) begin
                n_bad++;
                $display("[TB] FAIL burst_gap[%0d]: got %0d/%b want 1/%b", k, gap, gb, exp_gb[k]);
            end
            if ((g[0] && sb0.size() == 0) || (!g[0] && sb1.size() == 0)) begin
                n_cmp++; n_bad++;
                $display("[TB] FAIL burst_extra[%0d]: got gnt %b want no write", k, g);
                break;
            end
            e = g[0] ? sb0.pop_front() : sb1.pop_front();
            n_cmp++;
            if ({a, d, we} !== {e.addr, e.data, e.we}) begin
                n_bad++;
                $display("[TB] FAIL burst_write[%0d]: got %h/%h/%b want %h/%h/%b", k, a, d, we, e.addr, e.data, e.we);
            end
            advance(g);
        end
        n_cmp++; if (sb0.size() + sb1.size() != 0) begin n_bad++; $display("[TB] FAIL burst_left: got %0d want 0", sb0.size() + sb1.size()); end
    endtask

    task automatic test_range();
        logic [1:0] g; logic [14:0] a; logic [15:0] d; logic we; int gap; logic gb; exp_t e;
        logic [14:0] addrs[4] = '{15'h6FFF, 15'h7010, 15'h7000, 15'h700F};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            present(k < 2 ? 1 : 0, addrs[k], 16'h1000 + 16'(k), 1'b0);
            next_grant(g, a, d, we, gap, gb);
            n_cmp++;
            if (g !== (k < 2 ? 2'b10 : 2'b01)) begin
                n_bad++;
                $display("[TB] FAIL range_gnt[%0d]: got %b want %b", k, g, (k < 2 ? 2'b10 : 2'b01));
            end
            if (g == 2'b00) break;
            e = (k < 2) ? sb1.pop_front() : sb0.pop_front();
            n_cmp++;
            if ({a, d, we} !== {e.addr, e.data, e.we}) begin
                n_bad++;
                $display("[TB] FAIL range_write[%0d]: got %h/%h/%b want %h/%h/%b", k, a, d, we, e.addr, e.data, e.we);
            end
            @(posedge clk50m);
            #1 drop(k < 2 ? 1 : 0);
            @(negedge clk50m);
            n_cmp++; if (arb.err !== 1'b1) begin n_bad++; $display("[TB] FAIL range_err[%0d]: got %b want 1", k, arb.err); end
            if (k == 1) begin
                n_cmp++;
                if ({arb.bus_addr, arb.bus_we} !== {15'h7010, 1'b0}) begin
                    n_bad++;
                    $display("[TB] FAIL range_hold: got %h/%b want 7010/0", arb.bus_addr, arb.bus_we);
                end
                @(posedge clk50m); #1 arb.err_clr = 1'b1;
                @(posedge clk50m); #1 arb.err_clr = 1'b0;
                @(negedge clk50m);
                n_cmp++; if (arb.err !== 1'b0) begin n_bad++; $display("[TB] FAIL range_clr: got %b want 0", arb.err); end
                break;
            end
        end
        // In-range boundary writes must leave err clear.
        for (int k = 2; k < 4; k++) begin
            present(0, addrs[k], 16'h2000 + 16'(k), 1'b0);
            next_grant(g, a, d, we, gap, gb);
            n_cmp++; if (g !== 2'b01) begin n_bad++; $display("[TB] FAIL edge_gnt[%0d]: got %b want 01", k, g); end
            if (g == 2'b00) break;
            e = sb0.pop_front();
            n_cmp++;
            if ({a, d, we} !== {e.addr, e.data, e.we}) begin
                n_bad++;
                $display("[TB] FAIL edge_write[%0d]: got %h/%h/%b want %h/%h/%b", k, a, d, we, e.addr, e.data, e.we);
            end
            @(posedge clk50m);
            #1 drop(0);
            @(negedge clk50m);
            n_cmp++; if (arb.err !== 1'b0) begin n_bad++; $display("[TB] FAIL edge_err[%0d]: got %b want 0", k, arb.err); end
        end
        // err_clr held during an out-of-range WRITE cycle loses to the new error.
        present(1, 15'h7010, 16'h3333, 1'b0);
        next_grant(g, a, d, we, gap, gb);
        arb.err_clr = 1'b1;
        n_cmp++; if (g !== 2'b10) begin n_bad++; $display("[TB] FAIL setwins_gnt: got %b want 10", g); end
        @(posedge clk50m);
        #1;
        arb.err_clr = 1'b0;
        drop(1);
        @(negedge clk50m);
        n_cmp++; if (arb.err !== 1'b1) begin n_bad++; $display("[TB] FAIL setwins_err: got %b want 1", arb.err); end
    endtask

    task automatic test_reset_abort();
        logic [1:0] g; logic [14:0] a; logic [15:0] d; logic we; int gap; logic gb; exp_t e;
        do_reset();
        present(0, 15'h7001, 16'h4444, 1'b0);
        next_grant(g, a, d, we, gap, gb);
        n_cmp++; if (g !== 2'b01) begin n_bad++; $display("[TB] FAIL abort_first: got %b want 01", g); end
        rst = 1'b1;
        @(negedge clk50m);
        n_cmp++; if (arb.gnt !== 2'b00) begin n_bad++; $display("[TB] FAIL abort_gnt: got %b want 00", arb.gnt); end
        n_cmp++; if (arb.bus_we !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_we: got %b want 0", arb.bus_we); end
        n_cmp++; if (arb.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_busy: got %b want 0", arb.busy); end
        n_cmp++; if (arb.bus_addr !== 15'h0) begin n_bad++; $display("[TB] FAIL abort_addr: got %h want 0000", arb.bus_addr); end
        @(posedge clk50m);
        #1;
        rst = 1'b0;
        sb0.delete(); sb1.delete();
        present(0, 15'h7004, 16'h5555, 1'b0);
        present(1, 15'h700A, 16'h6666, 1'b0);
        next_grant(g, a, d, we, gap, gb);
        n_cmp++; if (g !== 2'b01) begin n_bad++; $display("[TB] FAIL abort_ptr: got %b want 01", g); end
        if (g == 2'b01) begin
            e = sb0.pop_front();
            n_cmp++;
            if ({a, d, we} !== {e.addr, e.data, e.we}) begin
                n_bad++;
                $display("[TB] FAIL abort_write: got %h/%h/%b want %h/%h/%b", a, d, we, e.addr, e.data, e.we);
            end
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        arb.req = 2'b00; arb.lock = 2'b00; arb.err_clr = 1'b0;
        arb.addr0 = '0; arb.addr1 = '0; arb.data0 = '0; arb.data1 = '0;
        test_reset();
        test_single();
        test_alternate();
        test_burst();
        test_range();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
